mem_arbiter: RTL and testbench

- Shares the CPU's single-ported unified memory between two requesters: port 0 (the multicycle CPU core) and port 1 (the debug/program loader).
- Each cycle it picks at most one requester and routes that requester's address, write data and write enable onto the memory port.
- It tracks outstanding reads and returns read data to the requester that issued them.
- Round-robin fairness, plus an optional lock so one requester can perform an atomic read-modify-write sequence.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_arbiter_rd_tag_pipe.sv | 38 +++
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port unified-memory arbiter.
// Covers the owner-state encoding, the port IDs and the read-tag format.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OwnFree = 2'b00,
        Own0    = 2'b01,
        Own1    = 2'b10
    } owner_e;

    localparam logic Port0Id = 1'b0;
    localparam logic Port1Id = 1'b1;

    localparam int unsigned RdLatMin = 1;
    localparam int unsigned RdLatMax = 4;

    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

    function automatic bit rd_lat_legal(input int unsigned lat);
        return (lat >= RdLatMin) && (lat <= RdLatMax);
    endfunction

endpackage

// File: rtl/mem_arbiter_rd_tag_pipe.sv
// Fixed-latency shift register of read tags. A tag pushed in the address
// cycle emerges DEPTH cycles later, aligned with the memory read data.
module rd_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic    clk,
    input  logic    rstb,
    input  rd_tag_t push_tag,
    output rd_tag_t pop_tag
);

    rd_tag_t pipe_q [DEPTH];
    rd_tag_t pipe_d [DEPTH];

    always_comb begin
        pipe_d[0] = push_tag;
        for (int i = 1; i < int'(DEPTH); i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign pop_tag = pipe_q[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the CPU's single-ported unified memory.
// Provides round-robin grants, an optional ownership lock, and read data routed back by tag.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic              r0_lock,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic              r1_lock,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_wr_ena,
    input  logic [DATA_W-1:0] mem_rd_data
);

    if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
        $error("mem_arbiter: RD_LAT must be in 1..4");
    end

    owner_e            owner_q, owner_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              gnt0, gnt1, sel;
    rd_tag_t           push_tag, pop_tag;
    logic              rvalid0, rvalid1;

    // Grant decode; every output is forced quiet while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        unique case (owner_q)
            Own0: gnt0 = r0_req;
            Own1: gnt1 = r1_req;
            default: begin
                if (r0_req && r1_req) begin
                    gnt0 = (last_q == Port1Id);
                    gnt1 = (last_q == Port0Id);
                end else begin
                    gnt0 = r0_req;
                    gnt1 = r1_req;
                end
            end
        endcase
        gnt0 = gnt0 & rstb;
        gnt1 = gnt1 & rstb;
    end

    always_comb begin
        owner_d = owner_q;
        unique case (owner_q)
            Own0: if (!r0_lock) owner_d = OwnFree;
            Own1: if (!r1_lock) owner_d = OwnFree;
            default: begin
                if (gnt0 && r0_lock) begin
                    owner_d = Own0;
                end else if (gnt1 && r1_lock) begin
                    owner_d = Own1;
                end
            end
        endcase
        last_d = gnt0 ? Port0Id : (gnt1 ? Port1Id : last_q);
    end

    // With no grant the bus keeps showing the last owner's inputs.
    always_comb begin
        sel         = gnt1 ? Port1Id : (gnt0 ? Port0Id : last_q);
        mem_addr    = '0;
        mem_wr_data = '0;
        if (rstb) begin
            mem_addr    = sel ? r1_addr : r0_addr;
            mem_wr_data = sel ? r1_wdata : r0_wdata;
        end
        mem_wr_ena = (gnt0 & r0_we) | (gnt1 & r1_we);
    end

    always_comb begin
        push_tag.valid = (gnt0 & ~r0_we) | (gnt1 & ~r1_we);
        push_tag.id    = gnt1 ? Port1Id : Port0Id;
    end

    rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_rd_tag_pipe (
        .clk      (clk),
        .rstb     (rstb),
        .push_tag (push_tag),
        .pop_tag  (pop_tag)
    );

    always_comb begin
        rvalid0  = rstb & pop_tag.valid & (pop_tag.id == Port0Id);
        rvalid1  = rstb & pop_tag.valid & (pop_tag.id == Port1Id);
        rdata0_d = rvalid0 ? mem_rd_data : rdata0_q;
        rdata1_d = rvalid1 ? mem_rd_data : rdata1_q;
    end

    assign r0_gnt    = gnt0;
    assign r1_gnt    = gnt1;
    assign r0_rvalid = rvalid0;
    assign r1_rvalid = rvalid1;
    assign r0_rdata  = rstb ? rdata0_d : '0;
    assign r1_rdata  = rstb ? rdata1_d : '0;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            owner_q  <= OwnFree;
            last_q   <= Port1Id;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            owner_q  <= owner_d;
            last_q   <= last_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with RD_LAT=3 and a small fixed-content memory model.
module tb_mem_arbiter;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned LAT = 3;

    logic          clk = 1'b0;
    logic          rstb;
    logic          r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock;
    logic [AW-1:0] r0_addr, r1_addr, mem_addr;
    logic [DW-1:0] r0_wdata, r1_wdata, mem_wr_data, mem_rd_data, r0_rdata, r1_rdata;
    logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_wr_ena;
    logic [DW-1:0] rd_pipe [LAT];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .RD_LAT (LAT)
    ) dut (
        .clk         (clk),
        .rstb        (rstb),
        .r0_req      (r0_req),
        .r0_we       (r0_we),
        .r0_lock     (r0_lock),
        .r0_addr     (r0_addr),
        .r0_wdata    (r0_wdata),
        .r0_gnt      (r0_gnt),
        .r0_rvalid   (r0_rvalid),
        .r0_rdata    (r0_rdata),
        .r1_req      (r1_req),
        .r1_we       (r1_we),
        .r1_lock     (r1_lock),
        .r1_addr     (r1_addr),
        .r1_wdata    (r1_wdata),
        .r1_gnt      (r1_gnt),
        .r1_rvalid   (r1_rvalid),
        .r1_rdata    (r1_rdata),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_ena  (mem_wr_ena),
        .mem_rd_data (mem_rd_data)
    );

    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        case (a)
            32'h10:  return 32'hDEAD_BEEF;
            32'h20:  return 32'hCAFE_0020;
            32'h30:  return 32'h0B0B_0030;
            32'h40:  return 32'h0C0C_0040;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        rd_pipe[0] <= rom(mem_addr);
        for (int i = 1; i < int'(LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rd_data = rd_pipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        rstb = 1'b0;
        r0_req = 1'b1; r0_we = 1'b1; r0_lock = 1'b0; r0_addr = 32'h77; r0_wdata = 32'h99;
        r1_req = 1'b0; r1_we = 1'b0; r1_lock = 1'b0; r1_addr = 32'h0;  r1_wdata = 32'h0;

        // reset with a live request: everything quiet
        next_cycle(); next_cycle(); sample();
        chk("rst_r0_gnt", r0_gnt, 0);
        chk("rst_r1_gnt", r1_gnt, 0);
        chk("rst_r0_rvalid", r0_rvalid, 0);
        chk("rst_r1_rvalid", r1_rvalid, 0);
        chk("rst_r0_rdata", r0_rdata, 0);
        chk("rst_r1_rdata", r1_rdata, 0);
        chk("rst_wr_ena", mem_wr_ena, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wr_data, 0);

        // c0: single r0 read of 0x10
        next_cycle(); rstb = 1'b1; r0_we = 1'b0; r0_addr = 32'h10; sample();
        chk("c0_r0_gnt", r0_gnt, 1);
        chk("c0_r1_gnt", r1_gnt, 0);
        chk("c0_mem_addr", mem_addr, 32'h10);
        chk("c0_wr_ena", mem_wr_ena, 0);
        // c1: idle, bus follows last owner (port 0)
        next_cycle(); r0_req = 1'b0; r0_addr = 32'h44; r1_addr = 32'h55; sample();
        chk("idle_r0_gnt", r0_gnt, 0);
        chk("idle_r1_gnt", r1_gnt, 0);
        chk("idle_wr_ena", mem_wr_ena, 0);
        chk("idle_mem_addr", mem_addr, 32'h44);
        chk("c1_r0_rvalid", r0_rvalid, 0);
        next_cycle(); sample();
        chk("c2_r0_rvalid", r0_rvalid, 0);
        next_cycle(); sample();
        chk("c3_r0_rvalid", r0_rvalid, 1);
        chk("c3_r0_rdata", r0_rdata, 32'hDEAD_BEEF);
        chk("c3_r1_rvalid", r1_rvalid, 0);
        chk("c3_r1_rdata", r1_rdata, 0);
        next_cycle(); sample();
        chk("c4_r0_rvalid", r0_rvalid, 0);
        chk("c4_r0_rdata_held", r0_rdata, 32'hDEAD_BEEF);

        // c5: r0 write 0x8 <= 0x1234
        next_cycle(); r0_req = 1'b1; r0_we = 1'b1; r0_addr = 32'h8; r0_wdata = 32'h1234; sample();
        chk("wr_r0_gnt", r0_gnt, 1);
        chk("wr_wr_ena", mem_wr_ena, 1);
        chk("wr_mem_addr", mem_addr, 32'h8);
        chk("wr_mem_wdata", mem_wr_data, 32'h1234);
        next_cycle(); r0_req = 1'b0; r0_we = 1'b0; sample();
        chk("wr_next_wr_ena", mem_wr_ena, 0);
        next_cycle(); next_cycle(); sample();
        chk("wr_r0_rvalid", r0_rvalid, 0);
        chk("wr_r1_rvalid", r1_rvalid, 0);

        // c9: r1 read 0x30, then reset before it returns
        next_cycle(); r1_req = 1'b1; r1_addr = 32'h30; sample();
        chk("c9_r1_gnt", r1_gnt, 1);
        next_cycle(); rstb = 1'b0; r1_req = 1'b0; sample();
        chk("mid_rst_mem_addr", mem_addr, 0);
        chk("mid_rst_mem_wdata", mem_wr_data, 0);
        chk("mid_rst_r0_rdata", r0_rdata, 0);
        chk("mid_rst_r1_rvalid", r1_rvalid, 0);
        next_cycle(); rstb = 1'b1; sample();
        chk("c11_r1_rvalid", r1_rvalid, 0);
        next_cycle(); sample();
        chk("c12_r1_rvalid", r1_rvalid, 0);
        chk("c12_r1_rdata", r1_rdata, 0);
        chk("c12_r0_rdata", r0_rdata, 0);

        // c13..c16: tie, port 0 first then alternating
        next_cycle(); r0_req = 1'b1; r1_req = 1'b1; r0_addr = 32'h10; r1_addr = 32'h40; sample();
        chk("tie0_r0_gnt", r0_gnt, 1);
        chk("tie0_r1_gnt", r1_gnt, 0);
        chk("tie0_mem_addr", mem_addr, 32'h10);
        next_cycle(); sample();
        chk("tie1_r1_gnt", r1_gnt, 1);
        chk("tie1_r0_gnt", r0_gnt, 0);
        chk("tie1_mem_addr", mem_addr, 32'h40);
        next_cycle(); sample();
        chk("tie2_r0_gnt", r0_gnt, 1);
        next_cycle(); sample();
        chk("tie3_r1_gnt", r1_gnt, 1);
        chk("tie_rd0_r0_rvalid", r0_rvalid, 1);
        chk("tie_rd0_r0_rdata", r0_rdata, 32'hDEAD_BEEF);
        chk("tie_rd0_r1_rvalid", r1_rvalid, 0);
        next_cycle(); r0_req = 1'b0; r1_req = 1'b0; sample();
        chk("tie_rd1_r1_rvalid", r1_rvalid, 1);
        chk("tie_rd1_r1_rdata", r1_rdata, 32'h0C0C_0040);
        chk("tie_rd1_r0_rvalid", r0_rvalid, 0);
        next_cycle(); sample();
        chk("tie_rd2_r0_rvalid", r0_rvalid, 1);
        next_cycle(); sample();
        chk("tie_rd3_r1_rvalid", r1_rvalid, 1);
        chk("tie_rd3_r1_rdata", r1_rdata, 32'h0C0C_0040);

        // c20: r0 alone, so port 1 wins the following tie
        next_cycle(); r0_req = 1'b1; sample();
        chk("c20_r0_gnt", r0_gnt, 1);
        // c21: r1 locked read of 0x20 while r0 waits
        next_cycle(); r1_req = 1'b1; r1_lock = 1'b1; r1_addr = 32'h20; sample();
        chk("lk0_r1_gnt", r1_gnt, 1);
        chk("lk0_r0_gnt", r0_gnt, 0);
        // c22: r1 writes 0x20 <= 5 and releases the lock
        next_cycle(); r1_we = 1'b1; r1_wdata = 32'h5; r1_lock = 1'b0; sample();
        chk("lk1_r1_gnt", r1_gnt, 1);
        chk("lk1_r0_gnt", r0_gnt, 0);
        chk("lk1_wr_ena", mem_wr_ena, 1);
        chk("lk1_mem_addr", mem_addr, 32'h20);
        chk("lk1_mem_wdata", mem_wr_data, 32'h5);
        next_cycle(); r1_req = 1'b0; r1_we = 1'b0; sample();
        chk("lk2_r0_gnt", r0_gnt, 1);
        chk("lk2_r1_gnt", r1_gnt, 0);
        chk("lk2_r0_rvalid", r0_rvalid, 1);
        chk("lk2_r0_rdata", r0_rdata, 32'hDEAD_BEEF);
        next_cycle(); r0_req = 1'b0; sample();
        chk("lk_rd_r1_rvalid", r1_rvalid, 1);
        chk("lk_rd_r1_rdata", r1_rdata, 32'hCAFE_0020);
        chk("lk_rd_r0_rvalid", r0_rvalid, 0);
        next_cycle(); sample();
        chk("c25_r1_rvalid", r1_rvalid, 0);
        next_cycle(); sample();
        chk("c26_r0_rvalid", r0_rvalid, 1);
        chk("c26_r1_rdata_held", r1_rdata, 32'hCAFE_0020);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
